// File: rtl/alu_p_register_detect_if.sv
// Bus between the SIMD ALU and its output stage: ALU result and control in,
// registered P, carry-outs and pattern-detect flags out.
interface alu_p_register_detect_if #(
    parameter int Width = 32
);
    logic             USE_SIMD;
    logic [Width-1:0] S;
    logic [1:0]       result_SIDM_carry_out;
    logic             CEP;
    logic             RSTP;
    logic [Width-1:0] P;
    logic [Width-1:0] P_fb;
    logic [1:0]       CARRYOUT;
    logic [1:0]       PATTERNDETECT;
    logic [1:0]       PATTERNBDETECT;
    logic [1:0]       PATTERNDETECTPAST;
    logic [1:0]       PATTERNBDETECTPAST;
    logic [1:0]       OVERFLOW;
    logic [1:0]       UNDERFLOW;

    modport master (
        output USE_SIMD, S, result_SIDM_carry_out, CEP, RSTP,
        input  P, P_fb, CARRYOUT, PATTERNDETECT, PATTERNBDETECT,
               PATTERNDETECTPAST, PATTERNBDETECTPAST, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  USE_SIMD, S, result_SIDM_carry_out, CEP, RSTP,
        output P, P_fb, CARRYOUT, PATTERNDETECT, PATTERNBDETECT,
               PATTERNDETECTPAST, PATTERNBDETECTPAST, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/alu_p_register_detect.sv
// P register stage after the 2x16 SIMD ALU: registers sum and carries, runs
// masked pattern detection and derives per-lane overflow/underflow flags.
module alu_p_register_detect #(
    parameter int               Width   = 32,
    parameter int               LaneW   = 16,
    parameter logic [Width-1:0] PATTERN = 32'h00000000,
    parameter logic [Width-1:0] MASK    = 32'hC0000000
) (
    input logic                   clk,
    input logic                   rst_n,
    alu_p_register_detect_if.slave bus
);
    localparam int Lanes = 2;

    // Bits that participate in the compare; a set MASK bit is a don't-care.
    localparam logic [Width-1:0] Care = ~MASK;

    logic [Width-1:0] p_q;
    logic [1:0]       carry_q;
    logic [1:0]       pd_q;
    logic [1:0]       pbd_q;
    logic [1:0]       pd_past_q;
    logic [1:0]       pbd_past_q;

    logic [1:0]       lane_match;
    logic [1:0]       lane_bmatch;
    logic             full_match;
    logic             full_bmatch;
    logic [1:0]       pd_next;
    logic [1:0]       pbd_next;
    logic [1:0]       carry_next;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        lane_match  = '0;
        lane_bmatch = '0;
        for (int i = 0; i < Lanes; i++) begin
            lane_match[i]  = ((bus.S[i*LaneW +: LaneW] ^ PATTERN[i*LaneW +: LaneW])
                              & Care[i*LaneW +: LaneW]) == '0;
            lane_bmatch[i] = ((bus.S[i*LaneW +: LaneW] ^ ~PATTERN[i*LaneW +: LaneW])
                              & Care[i*LaneW +: LaneW]) == '0;
        end
        full_match  = ((bus.S ^ PATTERN) & Care) == '0;
        full_bmatch = ((bus.S ^ ~PATTERN) & Care) == '0;
    end

    // In 32-bit mode the single compare result fills both flag bits, and the
    // lane-0 carry is internal to the wide add so it is not reported.
    always_comb begin
        pd_next    = {2{full_match}};
        pbd_next   = {2{full_bmatch}};
        carry_next = {bus.result_SIDM_carry_out[1], 1'b0};
        if (bus.USE_SIMD) begin
            pd_next    = lane_match;
            pbd_next   = lane_bmatch;
            carry_next = bus.result_SIDM_carry_out;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values; PAST takes the old DETECT, not the new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= '0;
            carry_q    <= '0;
            pd_q       <= '0;
            pbd_q      <= '0;
            pd_past_q  <= '0;
            pbd_past_q <= '0;
        end else if (bus.RSTP) begin
            p_q        <= '0;
            carry_q    <= '0;
            pd_q       <= '0;
            pbd_q      <= '0;
            pd_past_q  <= '0;
            pbd_past_q <= '0;
        end else if (bus.CEP) begin
            p_q        <= bus.S;
            carry_q    <= carry_next;
            pd_past_q  <= pd_q;
            pbd_past_q <= pbd_q;
            pd_q       <= pd_next;
            pbd_q      <= pbd_next;
        end
    end

    assign bus.P                  = p_q;
    assign bus.P_fb               = p_q;
    assign bus.CARRYOUT           = carry_q;
    assign bus.PATTERNDETECT      = pd_q;
    assign bus.PATTERNBDETECT     = pbd_q;
    assign bus.PATTERNDETECTPAST  = pd_past_q;
    assign bus.PATTERNBDETECTPAST = pbd_past_q;

    // A lane that matched both pattern and complement (fully masked) never
    // flags, because the current-cycle DETECT/BDETECT terms suppress it.
    assign bus.OVERFLOW  = pd_past_q  & ~pd_q & ~pbd_q;
    assign bus.UNDERFLOW = pbd_past_q & ~pd_q & ~pbd_q;
endmodule

// File: tb/tb_alu_p_register_detect.sv
// Directed bench for alu_p_register_detect: three instances with different
// masks share one stimulus stream; expected values are hand-computed.
module tb_alu_p_register_detect;
    logic        clk;
    logic        rst_n;
    logic        use_simd;
    logic [31:0] s;
    logic [1:0]  carry_in;
    logic        cep;
    logic        rstp;

    int checks = 0;
    int errors = 0;

    alu_p_register_detect_if #(.Width(32)) if_a ();
    alu_p_register_detect_if #(.Width(32)) if_b ();
    alu_p_register_detect_if #(.Width(32)) if_c ();

    assign if_a.USE_SIMD = use_simd;
    assign if_a.S        = s;
    assign if_a.result_SIDM_carry_out = carry_in;
    assign if_a.CEP      = cep;
    assign if_a.RSTP     = rstp;
    assign if_b.USE_SIMD = use_simd;
    assign if_b.S        = s;
    assign if_b.result_SIDM_carry_out = carry_in;
    assign if_b.CEP      = cep;
    assign if_b.RSTP     = rstp;
    assign if_c.USE_SIMD = use_simd;
    assign if_c.S        = s;
    assign if_c.result_SIDM_carry_out = carry_in;
    assign if_c.CEP      = cep;
    assign if_c.RSTP     = rstp;

    // a: default mask (two MSBs), b: two MSBs of each lane, c: lane 0 fully masked
    alu_p_register_detect dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    alu_p_register_detect #(.MASK(32'hC000C000)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    alu_p_register_detect #(.MASK(32'h0000FFFF)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        use_simd = 1'b0;
        s        = '0;
        carry_in = '0;
        cep      = 1'b0;
        rstp     = 1'b0;

        // Reset state
        #3;
        check("rst_p",       if_a.P,                      32'h0);
        check("rst_pfb",     if_a.P_fb,                   32'h0);
        check("rst_flags",   {24'h0, if_a.PATTERNDETECT, if_a.PATTERNBDETECT,
                              if_a.PATTERNDETECTPAST, if_a.PATTERNBDETECTPAST}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load all-ones, then assert rst_n mid-cycle
        cep = 1'b1; s = 32'hFFFFFFFF; carry_in = 2'b11;
        step();
        check("t1_p_load",   if_a.P,                      32'hFFFFFFFF);
        check("t1_pbd_load", {30'h0, if_a.PATTERNBDETECT}, 32'h3);
        check("t1_co_load",  {30'h0, if_a.CARRYOUT},      32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("t1_p_async",  if_a.P,                      32'h0);
        check("t1_co_async", {30'h0, if_a.CARRYOUT},      32'h0);
        check("t1_pbd_async",{30'h0, if_a.PATTERNBDETECT}, 32'h0);
        cep = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and clock enable
        cep = 1'b1; s = 32'h0; carry_in = 2'b00;
        step();
        check("t2_pd_zero",  {30'h0, if_a.PATTERNDETECT}, 32'h3);
        s = 32'h12345678;
        step();
        check("t2_p",        if_a.P,                      32'h12345678);
        check("t2_pfb",      if_a.P_fb,                   32'h12345678);
        check("t2_pd",       {30'h0, if_a.PATTERNDETECT}, 32'h0);
        check("t2_pdpast",   {30'h0, if_a.PATTERNDETECTPAST}, 32'h3);
        check("t2_ovf",      {30'h0, if_a.OVERFLOW},      32'h3);
        cep = 1'b0; s = 32'h0;
        repeat (3) step();
        check("t2_p_hold",   if_a.P,                      32'h12345678);
        check("t2_past_hold",{30'h0, if_a.PATTERNDETECTPAST}, 32'h3);
        check("t2_pd_hold",  {30'h0, if_a.PATTERNDETECT}, 32'h0);

        // 32-bit mode detect sequence, MASK = C0000000
        cep = 1'b1; use_simd = 1'b0; s = 32'h3FFFFFF0;
        step();
        check("t3_pd_a",     {30'h0, if_a.PATTERNDETECT}, 32'h0);
        check("t3_pbd_a",    {30'h0, if_a.PATTERNBDETECT}, 32'h0);
        s = 32'h40000000;
        step();
        check("t3_pd_b",     {30'h0, if_a.PATTERNDETECT}, 32'h3);
        check("t3_ovf_b",    {30'h0, if_a.OVERFLOW},      32'h0);
        s = 32'h00000005;
        step();
        check("t3_pd_c",     {30'h0, if_a.PATTERNDETECT}, 32'h0);
        check("t3_pbd_c",    {30'h0, if_a.PATTERNBDETECT}, 32'h0);
        check("t3_ovf_c",    {30'h0, if_a.OVERFLOW},      32'h3);
        check("t3_unf_c",    {30'h0, if_a.UNDERFLOW},     32'h0);

        // RSTP wins over CEP
        rstp = 1'b1; s = 32'hAAAA5555; carry_in = 2'b10;
        step();
        check("t5_p_clr",    if_a.P,                      32'h0);
        check("t5_past_clr", {30'h0, if_a.PATTERNDETECTPAST}, 32'h0);
        check("t5_ovf_clr",  {30'h0, if_a.OVERFLOW},      32'h0);
        check("t5_co_clr",   {30'h0, if_a.CARRYOUT},      32'h0);
        rstp = 1'b0;
        step();
        check("t5_p_load",   if_a.P,                      32'hAAAA5555);

        // SIMD lane underflow, MASK = C000C000 (instance b)
        use_simd = 1'b1; carry_in = 2'b10; s = 32'hC0010000;
        step();
        check("t4_pd_1",     {30'h0, if_b.PATTERNDETECT}, 32'h1);
        check("t4_pbd_1",    {30'h0, if_b.PATTERNBDETECT}, 32'h0);
        check("t4_co_1",     {30'h0, if_b.CARRYOUT},      32'h2);
        s = 32'hBFFF0000;
        step();
        check("t4_pd_2",     {30'h0, if_b.PATTERNDETECT}, 32'h1);
        check("t4_pbd_2",    {30'h0, if_b.PATTERNBDETECT}, 32'h2);
        s = 32'h00010000;
        step();
        check("t4_pbdpast_3",{30'h0, if_b.PATTERNBDETECTPAST}, 32'h2);
        check("t4_unf_3",    {30'h0, if_b.UNDERFLOW},     32'h2);
        check("t4_ovf_3",    {30'h0, if_b.OVERFLOW},      32'h0);
        check("t4_co_3",     {30'h0, if_b.CARRYOUT},      32'h2);
        // Lane 0 of instance c is fully masked: both detects set, no flags
        check("fm_pd",       {30'h0, if_c.PATTERNDETECT}, 32'h1);
        check("fm_pbd",      {30'h0, if_c.PATTERNBDETECT}, 32'h1);
        check("fm_ovf",      {30'h0, if_c.OVERFLOW},      32'h0);
        check("fm_unf",      {30'h0, if_c.UNDERFLOW},     32'h0);

        // Lane-0 carry masking follows the mode
        use_simd = 1'b0; carry_in = 2'b11;
        step();
        check("t6_co_wide",  {30'h0, if_a.CARRYOUT},      32'h2);
        use_simd = 1'b1;
        step();
        check("t6_co_simd",  {30'h0, if_a.CARRYOUT},      32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
